// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS fetch path. Holds the PC
//                source select encoding and the default reset and exception
//                vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // PC source select code, 3 bits.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_EXC  = 3'd4,
        SRC_PEND = 3'd5
    } pc_src_e;

    localparam logic [31:0] c_reset_vector = 32'h0000_0000;
    localparam logic [31:0] c_exc_vector   = 32'h8000_0180;

    // Sources that move the PC somewhere other than the next sequential slot
    // and therefore have their target checked for alignment.
    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_J) ||
               (src == SRC_JR) || (src == SRC_PEND);
    endfunction

    // Sources that may be captured into the pending register during a stall.
    function automatic logic is_capturable(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_J) || (src == SRC_JR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_src_select.sv
`default_nettype none
// ============================================================================
//  Module      : pc_src_select
//  Description : Combinational priority encoder and target mux for the next
//                PC. Priority: exception > jump_reg > jump > branch >
//                pending > sequential.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_src_select
    import mips_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(c_exc_vector)
) (
    input  logic             i_exception,
    input  logic             i_jump_reg,
    input  logic [WIDTH-1:0] i_reg_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_address,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_pending,
    input  logic [WIDTH-1:0] i_pend_target,
    input  logic [WIDTH-1:0] i_pc_plus4,
    output logic [WIDTH-1:0] o_target,
    output pc_src_e          o_src
);

    // Pick the highest-priority active source and its target address.
    always_comb begin
        o_src    = SRC_SEQ;
        o_target = i_pc_plus4;
        if (i_exception) begin
            o_src    = SRC_EXC;
            o_target = EXC_VECTOR;
        end else if (i_jump_reg) begin
            o_src    = SRC_JR;
            o_target = i_reg_target;
        end else if (i_jump) begin
            o_src    = SRC_J;
            o_target = i_jump_address;
        end else if (i_branch_taken) begin
            o_src    = SRC_BR;
            o_target = i_branch_target;
        end else if (i_pending) begin
            o_src    = SRC_PEND;
            o_target = i_pend_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Registered next-PC generator. Holds the architectural PC,
//                captures redirects requested during a stall, emits a
//                one-cycle flush pulse on every applied redirect and diverts
//                misaligned targets to the exception vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(c_reset_vector),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(c_exc_vector),
    parameter int               INSTR_BYTES  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_address,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exception,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             misaligned,
    output logic             pending
);

    // Low address bits that must be zero for an instruction-aligned target.
    localparam logic [WIDTH-1:0] c_align_mask = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] c_step       = WIDTH'(INSTR_BYTES);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_pending;
    logic             r_flush;
    logic             r_misaligned;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_target;
    pc_src_e          w_src;
    logic             w_misalign;

    // Sequential successor; wraps naturally at the top of the address space.
    assign w_pc_plus4 = r_pc + c_step;
    assign w_misalign = |(w_target & c_align_mask);

    pc_src_select #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_src_select (
        .i_exception     (exception),
        .i_jump_reg      (jump_reg),
        .i_reg_target    (reg_target),
        .i_jump          (jump),
        .i_jump_address  (jump_address),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_pending       (r_pending),
        .i_pend_target   (r_pend_target),
        .i_pc_plus4      (w_pc_plus4),
        .o_target        (w_target),
        .o_src           (w_src)
    );

    // PC, pending-redirect and pulse registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
            r_pending     <= 1'b0;
            r_flush       <= 1'b0;
            r_misaligned  <= 1'b0;
        end else if (w_src == SRC_EXC) begin
            // Exceptions bypass the stall and discard any captured redirect.
            r_pc         <= EXC_VECTOR;
            r_pending    <= 1'b0;
            r_flush      <= 1'b1;
            r_misaligned <= 1'b0;
        end else if (stall) begin
            // PC holds; a new redirect overwrites any earlier captured one.
            // Alignment is judged later, when the capture is applied.
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            if (is_capturable(w_src)) begin
                r_pend_target <= w_target;
                r_pending     <= 1'b1;
            end
        end else if (is_redirect(w_src)) begin
            r_pending <= 1'b0;
            r_flush   <= 1'b1;
            if (w_misalign) begin
                r_pc         <= EXC_VECTOR;
                r_misaligned <= 1'b1;
            end else begin
                r_pc         <= w_target;
                r_misaligned <= 1'b0;
            end
        end else begin
            r_pc         <= w_pc_plus4;
            r_pending    <= 1'b0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign flush      = r_flush;
    assign misaligned = r_misaligned;
    assign pending    = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_next_unit
//  Description : Self-checking bench for pc_next_unit: directed scenarios
//                against fixed expected values plus randomized traffic
//                against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    localparam int          WIDTH = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] EV    = 32'h8000_0180;

    logic        clock = 1'b0;
    logic        reset_n, stall, branch_taken, jump, jump_reg, exception;
    logic [31:0] branch_target, jump_address, reg_target;
    logic [31:0] pc, pc_plus4;
    logic        flush, misaligned, pending;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_ptgt;
    logic        m_flush, m_mis, m_pend;

    pc_next_unit #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV),
        .INSTR_BYTES  (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_address  (jump_address),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .exception     (exception),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .misaligned    (misaligned),
        .pending       (pending)
    );

    always #5 clock = ~clock;

    // Apply the rules of one clock edge to the model using current inputs.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = 1'b1;
        tgt   = '0;
        if (!reset_n) begin
            m_pc = RV; m_flush = 0; m_mis = 0; m_pend = 0; m_ptgt = '0;
        end else if (exception) begin
            m_pc = EV; m_flush = 1; m_mis = 0; m_pend = 0;
        end else if (stall) begin
            m_flush = 0; m_mis = 0;
            if (jump_reg)          begin m_ptgt = reg_target;    m_pend = 1; end
            else if (jump)         begin m_ptgt = jump_address;  m_pend = 1; end
            else if (branch_taken) begin m_ptgt = branch_target; m_pend = 1; end
        end else begin
            if (jump_reg)          tgt = reg_target;
            else if (jump)         tgt = jump_address;
            else if (branch_taken) tgt = branch_target;
            else if (m_pend)       tgt = m_ptgt;
            else                   redir = 1'b0;
            if (redir) begin
                m_flush = 1;
                if (tgt % 4 != 0) begin m_pc = EV;  m_mis = 1; end
                else              begin m_pc = tgt; m_mis = 0; end
            end else begin
                m_pc = m_pc + 32'd4; m_flush = 0; m_mis = 0;
            end
            m_pend = 0;
        end
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; exception = 0;
        branch_target = '0; jump_address = '0; reg_target = '0;
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; idle();
        tick(); tick();
        checks++; if (pc !== RV)       begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        checks++; if (flush !== 1'b0)  begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        reset_n = 1; idle();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 32'(i * 4);
            checks++; if (pc !== exp) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush[%0d]: got %b want 0", i, flush); end
        end
    endtask

    task automatic test_priority();
        idle(); jump = 1; jump_address = 32'h0040_0100;
        branch_taken = 1; branch_target = 32'h0000_0300;
        tick();
        checks++; if (pc !== 32'h0040_0100) begin errors++; $display("FAIL prio_pc: got %h want 00400100", pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush: got %b want 1", flush); end
        idle(); tick();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL prio_flush_drop: got %b want 0", flush); end
        checks++; if (pc !== 32'h0040_0104) begin errors++; $display("FAIL prio_pc_next: got %h want 00400104", pc); end
    endtask

    task automatic test_stall_capture();
        logic [31:0] held;
        held = pc;
        idle(); stall = 1; branch_taken = 1; branch_target = 32'h200;
        tick();
        branch_taken = 0; branch_target = '0;
        tick(); tick();
        checks++; if (pc !== held) begin errors++; $display("FAIL stall_hold: got %h want %h", pc, held); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL stall_pending: got %b want 1", pending); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush: got %b want 0", flush); end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL release_pc: got %h want 00000200", pc); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL release_flush: got %b want 1", flush); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL release_pending: got %b want 0", pending); end
    endtask

    task automatic test_exception_stall();
        idle(); stall = 1; jump = 1; jump_address = 32'h1000;
        tick();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL exc_pre_pending: got %b want 1", pending); end
        jump = 0; exception = 1;
        tick();
        checks++; if (pc !== EV) begin errors++; $display("FAIL exc_pc: got %h want %h", pc, EV); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush: got %b want 1", flush); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL exc_pending: got %b want 0", pending); end
        idle(); tick();
        checks++; if (pc !== EV + 32'd4) begin errors++; $display("FAIL exc_after_pc: got %h want %h", pc, EV + 32'd4); end
    endtask

    task automatic test_misaligned();
        idle(); jump_reg = 1; reg_target = 32'h0000_0102;
        tick();
        checks++; if (pc !== EV) begin errors++; $display("FAIL mis_pc: got %h want %h", pc, EV); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", misaligned); end
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush: got %b want 1", flush); end
        idle(); tick();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_drop: got %b want 0", misaligned); end
        // Misaligned capture during a stall is only judged on release.
        stall = 1; branch_taken = 1; branch_target = 32'h0000_0301;
        tick();
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_capture: got %b want 0", misaligned); end
        idle(); tick();
        checks++; if (misaligned !== 1'b1 || pc !== EV) begin errors++; $display("FAIL mis_release: got mis=%b pc=%h want mis=1 pc=%h", misaligned, pc, EV); end
    endtask

    task automatic test_wrap();
        idle(); jump = 1; jump_address = 32'hFFFF_FFFC;
        tick();
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
        idle(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc); end
        checks++; if (flush !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL wrap_flags: got flush=%b mis=%b want 0 0", flush, misaligned); end
    endtask

    task automatic test_reset_pending();
        idle(); stall = 1; branch_taken = 1; branch_target = 32'h400;
        tick();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rstp_pre: got %b want 1", pending); end
        branch_taken = 0; reset_n = 0;
        tick();
        checks++; if (pc !== RV || pending !== 1'b0) begin errors++; $display("FAIL rstp_reset: got pc=%h pend=%b want pc=%h pend=0", pc, pending, RV); end
        reset_n = 1; stall = 0;
        tick();
        checks++; if (pc !== RV + 32'd4 || flush !== 1'b0) begin errors++; $display("FAIL rstp_discard: got pc=%h flush=%b want pc=%h flush=0", pc, flush, RV + 32'd4); end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int n = 0; n < 600; n++) begin
            reset_n      = ($urandom_range(0, 99) != 0);
            stall        = ($urandom_range(0, 99) < 30);
            exception    = ($urandom_range(0, 99) < 4);
            jump_reg     = ($urandom_range(0, 99) < 12);
            jump         = ($urandom_range(0, 99) < 12);
            branch_taken = ($urandom_range(0, 99) < 15);
            t = $urandom; if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00; reg_target    = t;
            t = $urandom; if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00; jump_address  = t;
            t = $urandom; if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00; branch_target = t;
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
            checks++; if (pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4[%0d]: got %h want %h", n, pc_plus4, m_pc + 32'd4); end
            checks++; if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush, m_flush); end
            checks++; if (misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, misaligned, m_mis); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending[%0d]: got %b want %b", n, pending, m_pend); end
        end
        reset_n = 1; idle();
    endtask

    initial begin
        m_pc = RV; m_ptgt = '0; m_flush = 0; m_mis = 0; m_pend = 0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_capture();
        test_exception_stall();
        test_misaligned();
        test_wrap();
        test_reset_pending();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
